tt_op_sweeper: RTL and testbench

On-chip stimulus initiator and result capture for the processor core. Drives the core's two 4-bit operand inputs (ui_in / uio_in side) through a fixed sweep and samples the 8-bit result (uo_out side) once per vector. Compresses the results into a 16-bit MISR signature so that silicon bring-up can compare against a golden value. Sits between the top-level pad mux and the processor core, and is active only in self-test.

---
 rtl/tt_op_sweeper_if.sv | 40 ++++
 rtl/tt_op_sweeper.sv | 169 ++++++++++++++++
 tb/tb_tt_op_sweeper.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_op_sweeper_if.sv
// ----------------------------------------------------------------------------
// tt_op_sweeper_if
// Bundles the self-test sweeper's control, result-capture and status signals.
//
//   start      : one-cycle pulse that begins a sweep when the sweeper is idle
//   full_mode  : sweep length select, sampled with start (0 = 32, 1 = 256)
//   abort      : synchronous abort back to idle
//   res_in     : processor result bus (uo_out)
//   a_out      : operand A to the processor (ui_in[3:0])
//   b_out      : operand B to the processor (uio_in[3:0])
//   busy       : high while a sweep is in progress
//   done       : one-cycle pulse after the final capture
//   vec_idx    : number of vectors captured so far
//   signature  : MISR signature, stable after done
//
// master: the side that drives start/abort/res_in (pad mux / bench)
// slave : the sweeper itself
// ----------------------------------------------------------------------------
interface tt_op_sweeper_if;
    logic        start;
    logic        full_mode;
    logic        abort;
    logic [7:0]  res_in;
    logic [3:0]  a_out;
    logic [3:0]  b_out;
    logic        busy;
    logic        done;
    logic [8:0]  vec_idx;
    logic [15:0] signature;

    modport master (
        output start, full_mode, abort, res_in,
        input  a_out, b_out, busy, done, vec_idx, signature
    );

    modport slave (
        input  start, full_mode, abort, res_in,
        output a_out, b_out, busy, done, vec_idx, signature
    );
endinterface

// File: rtl/tt_op_sweeper.sv
// ----------------------------------------------------------------------------
// tt_op_sweeper
// Self-test stimulus initiator and result capture for the processor core.
// Steps the two 4-bit operands through a fixed sweep, holds each vector for
// SETTLE clocks, then folds the 8-bit core result into a 16-bit MISR.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : tt_op_sweeper_if.slave (start/full_mode/abort/res_in in,
//          a_out/b_out/busy/done/vec_idx/signature out)
//
// Parameters:
//   SETTLE : clocks each vector is held before res_in is sampled (1..15)
//   POLY   : MISR feedback polynomial
//   SEED   : MISR value loaded when a sweep starts
// ----------------------------------------------------------------------------
module tt_op_sweeper #(
    parameter int unsigned SETTLE = 2,
    parameter logic [15:0] POLY   = 16'h1021,
    parameter logic [15:0] SEED   = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    tt_op_sweeper_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    // One MISR update: shift with polynomial feedback, then fold in the result.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [7:0]  res);
        return {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ {8'h00, res};
    endfunction

    // Operand pair {a, b} for sweep vector idx.
    // BASIC: b walks 0..15 with a=0, then a walks 0..15 with b=0.
    // FULL : a is the high nibble of idx, b the low nibble.
    function automatic logic [7:0] vec_operands(input logic       full,
                                                input logic [7:0] idx);
        if (full) begin
            return idx;
        end else if (!idx[4]) begin
            return {4'h0, idx[3:0]};
        end else begin
            return {idx[3:0], 4'h0};
        end
    endfunction

    logic [1:0]  state_q, state_d;
    logic        full_q,  full_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [8:0]  vidx_q,  vidx_d;
    logic [3:0]  a_q,     a_d;
    logic [3:0]  b_q,     b_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [15:0] sig_q,   sig_d;

    logic [8:0]  next_vec;
    logic        last_vec;

    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        cnt_d    = cnt_q;
        vidx_d   = vidx_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sig_d    = sig_q;
        next_vec = vidx_q + 9'd1;
        // vidx_q is also the index of the vector currently being held.
        last_vec = full_q ? (vidx_q == 9'd255) : (vidx_q == 9'd31);

        case (state_q)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = S_HOLD;
                    full_d  = bus.full_mode;
                    sig_d   = SEED;
                    vidx_d  = 9'd0;
                    a_d     = 4'h0;
                    b_d     = 4'h0;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                end
            end

            S_HOLD: begin
                if (bus.abort) begin
                    // signature and vec_idx freeze where they are
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    a_d     = 4'h0;
                    b_d     = 4'h0;
                end else if (cnt_q == 4'd0) begin
                    sig_d  = misr_step(sig_q, bus.res_in);
                    vidx_d = next_vec;
                    if (last_vec) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        a_d     = 4'h0;
                        b_d     = 4'h0;
                    end else begin
                        {a_d, b_d} = vec_operands(full_q, next_vec[7:0]);
                        cnt_d      = RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_FINISH: begin
                // done is high for exactly this one cycle
                state_d = S_IDLE;
                busy_d  = 1'b0;
                a_d     = 4'h0;
                b_d     = 4'h0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                a_d     = 4'h0;
                b_d     = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            full_q  <= 1'b0;
            cnt_q   <= 4'd0;
            vidx_q  <= 9'd0;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            vidx_q  <= vidx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vec_idx   = vidx_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_tt_op_sweeper.sv
// ----------------------------------------------------------------------------
// tb_tt_op_sweeper
// Self-checking bench for tt_op_sweeper: a table of whole-sweep records plus
// hand-written abort / reset / start-with-abort sequences. Expected operand
// pairs are queued when a sweep is launched and checked every busy cycle.
// ----------------------------------------------------------------------------
module tb_tt_op_sweeper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_op_sweeper_if bus_if ();

    tt_op_sweeper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Core result model: 0 = tied low, 1 = {a,b} delayed one cycle, 2 = 0xA5.
    int         res_mode = 0;
    logic [7:0] res_dly  = 8'h00;
    always @(posedge clk) res_dly <= {bus_if.a_out, bus_if.b_out};
    assign bus_if.res_in = (res_mode == 0) ? 8'h00 :
                           (res_mode == 1) ? res_dly : 8'hA5;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {a,b} for vector i.
    function automatic logic [7:0] vec_ab(input bit full, input int i);
        int a, b;
        if (full) begin
            a = i / 16;
            b = i % 16;
        end else if (i < 16) begin
            a = 0;
            b = i;
        end else begin
            a = i - 16;
            b = 0;
        end
        return {4'(a), 4'(b)};
    endfunction

    function automatic logic [15:0] model_sig(input bit full, input int mode,
                                              input int nvec);
        logic [15:0] s;
        logic [7:0]  r;
        s = 16'h0000;
        for (int i = 0; i < nvec; i++) begin
            r = (mode == 0) ? 8'h00 : (mode == 1) ? vec_ab(full, i) : 8'hA5;
            if (s[15]) s = (s << 1) ^ 16'h1021;
            else       s = s << 1;
            s = s ^ {8'h00, r};
        end
        return s;
    endfunction

    // Scoreboard: one entry per expected busy cycle.
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && bus_if.busy) begin
            if (exp_q.size() == 0) begin
                check("vec_extra_busy", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("vec_ab", {24'h0, bus_if.a_out, bus_if.b_out}, {24'h0, e});
            end
        end
    end

    typedef struct {
        bit          full;
        int          mode;
        int          restart_at;
        int          exp_vidx;
        logic [15:0] exp_sig;
        int          exp_busy;
    } sweep_t;

    sweep_t tbl[6];

    task automatic queue_sweep(input bit full);
        int n;
        n = full ? 256 : 32;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(vec_ab(full, i));
            exp_q.push_back(vec_ab(full, i));
        end
    endtask

    task automatic run_sweep(input string tag, input sweep_t v);
        int busy_n, done_n;
        bit seen;
        logic [15:0] sig_end;
        res_mode = v.mode;
        @(negedge clk);
        bus_if.full_mode = v.full;
        bus_if.start     = 1'b1;
        queue_sweep(v.full);
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.full_mode = ~v.full;  // must have been latched at start
        busy_n = 0;
        done_n = 0;
        seen   = 1'b0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            bus_if.start = (c == v.restart_at);
            if (bus_if.busy) busy_n++;
            if (bus_if.done) begin
                done_n++;
                seen = 1'b1;
            end
            if (!seen) @(negedge clk);
        end
        bus_if.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
        check({tag, "_vec_idx"}, 32'(bus_if.vec_idx), 32'(v.exp_vidx));
        check({tag, "_signature"}, 32'(bus_if.signature), 32'(v.exp_sig));
        check({tag, "_busy_at_done"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_ab_at_done"}, {24'h0, bus_if.a_out, bus_if.b_out}, 32'd0);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        sig_end = bus_if.signature;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, "_sig_hold"}, 32'(bus_if.signature), 32'(sig_end));
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_any;

        tbl[0] = '{full: 1'b0, mode: 0, restart_at: -1, exp_vidx: 32,  exp_sig: 16'h0000,            exp_busy: 64};
        tbl[1] = '{full: 1'b0, mode: 1, restart_at: -1, exp_vidx: 32,  exp_sig: model_sig(0, 1, 32),  exp_busy: 64};
        tbl[2] = '{full: 1'b1, mode: 1, restart_at: -1, exp_vidx: 256, exp_sig: model_sig(1, 1, 256), exp_busy: 512};
        tbl[3] = '{full: 1'b0, mode: 2, restart_at: -1, exp_vidx: 32,  exp_sig: model_sig(0, 2, 32),  exp_busy: 64};
        tbl[4] = '{full: 1'b1, mode: 1, restart_at: 10, exp_vidx: 256, exp_sig: model_sig(1, 1, 256), exp_busy: 512};
        tbl[5] = '{full: 1'b0, mode: 1, restart_at: 10, exp_vidx: 32,  exp_sig: model_sig(0, 1, 32),  exp_busy: 64};

        rst              = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.abort     = 1'b0;
        bus_if.full_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_ab", {24'h0, bus_if.a_out, bus_if.b_out}, 32'd0);
        check("rst_vec_idx", 32'(bus_if.vec_idx), 32'd0);
        check("rst_signature", 32'(bus_if.signature), 32'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(bus_if.busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_sweep($sformatf("sweep%0d", k), tbl[k]);
        end

        // start and abort together while idle: abort wins
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        check("start_abort_idle_busy", 32'(bus_if.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("start_abort_idle_stay", 32'(bus_if.busy), 32'd0);

        // abort while vector 5 is being held
        res_mode = 1;
        @(negedge clk);
        bus_if.full_mode = 1'b1;
        bus_if.start     = 1'b1;
        queue_sweep(1'b1);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_pre_vec_idx", 32'(bus_if.vec_idx), 32'd5);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_ab", {24'h0, bus_if.a_out, bus_if.b_out}, 32'd0);
        check("abort_vec_idx", 32'(bus_if.vec_idx), 32'd5);
        check("abort_signature", 32'(bus_if.signature), 32'(model_sig(1, 1, 5)));
        exp_q.delete();
        done_any = bus_if.done;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            done_any |= bus_if.done;
        end
        check("abort_no_done", 32'(done_any), 32'd0);
        check("abort_freeze_vec_idx", 32'(bus_if.vec_idx), 32'd5);
        run_sweep("after_abort", tbl[2]);

        // asynchronous reset in the middle of a HOLD
        res_mode = 1;
        @(negedge clk);
        bus_if.full_mode = 1'b1;
        bus_if.start     = 1'b1;
        queue_sweep(1'b1);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_b", 32'(bus_if.b_out), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        check("mid_rst_ab", {24'h0, bus_if.a_out, bus_if.b_out}, 32'd0);
        check("mid_rst_vec_idx", 32'(bus_if.vec_idx), 32'd0);
        check("mid_rst_signature", 32'(bus_if.signature), 32'h0000);
        check("mid_rst_done", 32'(bus_if.done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        done_any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            done_any |= bus_if.done | bus_if.busy;
        end
        check("post_rst_idle", 32'(done_any), 32'd0);
        check("post_rst_vec_idx", 32'(bus_if.vec_idx), 32'd0);
        run_sweep("after_rst", tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
